// File: rtl/tlb_refill_walker_pkg.sv
// Shared types and sizing for the TLB refill page-table walker.
// TLB_WALK_L2_EN selects the two-level walk (adds S_L1FETCH).
package tlb_refill_walker_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int IDX_W       = $clog2(TLB_ENTRIES);
    localparam int PTE_V_BIT   = 0;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef TLB_WALK_L2_EN
        S_L1FETCH,
`endif
        S_FETCH,
        S_WRITE,
        S_FAULT
    } state_t;

endpackage

// File: rtl/tlb_refill_walker_repl.sv
// Round-robin replacement pointer for TLB refills.
// Wraps naturally at TLB_ENTRIES.
module tlb_repl_ptr
    import tlb_refill_walker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [IDX_W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/tlb_refill_walker.sv
// Page-table walker that refills one TLB entry per miss.
// Define TLB_WALK_L2_EN for a two-level walk; default is a linear table.
module tlb_refill_walker
    import tlb_refill_walker_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_req_i,
    input  logic [31:0] miss_vaddr_i,
    input  logic [31:0] ptbase_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        tlb_we_o,
    output logic [3:0]  tlb_windex_o,
    output logic [19:0] tlb_vpn_o,
    output logic [19:0] tlb_ppn_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o
);

    state_t           state;
    logic [19:0]      vpn_q;
    logic             abort_q;
    logic [IDX_W-1:0] ptr;
    logic             ptr_inc;
    logic             aborting;
    logic             pte_bad;

    assign ptr_inc  = (state == S_WRITE);
    assign aborting = abort_q | flush_i;
    assign pte_bad  = mem_err_i | ~mem_rdata_i[PTE_V_BIT];

`ifdef TLB_WALK_L2_EN
    logic unused_bits;
    assign unused_bits = ^{ptbase_i[11:0], miss_vaddr_i[11:0],
                           mem_rdata_i[11:1]};
`else
    logic unused_bits;
    assign unused_bits = ^{ptbase_i[21:0], miss_vaddr_i[11:0],
                           mem_rdata_i[11:1]};
`endif

    tlb_repl_ptr u_repl (
        .clk (clk),
        .rst (rst),
        .inc (ptr_inc),
        .ptr (ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            vpn_q        <= '0;
            abort_q      <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            tlb_we_o     <= 1'b0;
            tlb_windex_o <= '0;
            tlb_vpn_o    <= '0;
            tlb_ppn_o    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            fault_o      <= 1'b0;
        end else begin
            tlb_we_o <= 1'b0;
            done_o   <= 1'b0;
            fault_o  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (miss_req_i && !flush_i) begin
                        vpn_q     <= miss_vaddr_i[31:12];
                        mem_req_o <= 1'b1;
                        busy_o    <= 1'b1;
`ifdef TLB_WALK_L2_EN
                        state      <= S_L1FETCH;
                        mem_addr_o <= {ptbase_i[31:12],
                                       miss_vaddr_i[31:22], 2'b00};
`else
                        state      <= S_FETCH;
                        mem_addr_o <= {ptbase_i[31:22],
                                       miss_vaddr_i[31:12], 2'b00};
`endif
                    end
                end
`ifdef TLB_WALK_L2_EN
                S_L1FETCH: begin
                    if (mem_ack_i) begin
                        abort_q <= 1'b0;
                        if (aborting) begin
                            state     <= S_IDLE;
                            mem_req_o <= 1'b0;
                            busy_o    <= 1'b0;
                        end else if (pte_bad) begin
                            state     <= S_FAULT;
                            mem_req_o <= 1'b0;
                            fault_o   <= 1'b1;
                        end else begin
                            // request stays high straight into the leaf fetch
                            state      <= S_FETCH;
                            mem_addr_o <= {mem_rdata_i[31:12],
                                           vpn_q[9:0], 2'b00};
                        end
                    end else if (flush_i) begin
                        abort_q <= 1'b1;
                    end
                end
`endif
                S_FETCH: begin
                    if (mem_ack_i) begin
                        abort_q   <= 1'b0;
                        mem_req_o <= 1'b0;
                        if (aborting) begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end else if (pte_bad) begin
                            state   <= S_FAULT;
                            fault_o <= 1'b1;
                        end else begin
                            state        <= S_WRITE;
                            tlb_we_o     <= 1'b1;
                            done_o       <= 1'b1;
                            tlb_windex_o <= ptr;
                            tlb_vpn_o    <= vpn_q;
                            tlb_ppn_o    <= mem_rdata_i[31:12];
                        end
                    end else if (flush_i) begin
                        abort_q <= 1'b1;
                    end
                end
                S_WRITE, S_FAULT: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    mem_req_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Scoreboard bench for tlb_refill_walker: memory responder and result monitor.
// Define TLB_WALK_L2_EN to exercise the two-level walk.
module tb_tlb_refill_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req_i;
    logic [31:0] miss_vaddr_i;
    logic [31:0] ptbase_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        tlb_we_o;
    logic [3:0]  tlb_windex_o;
    logic [19:0] tlb_vpn_o;
    logic [19:0] tlb_ppn_o;
    logic        busy_o;
    logic        done_o;
    logic        fault_o;

    typedef struct {
        logic [31:0] data;
        bit          err;
    } pte_t;

    typedef struct {
        bit          is_fault;
        logic [3:0]  idx;
        logic [19:0] vpn;
        logic [19:0] ppn;
    } res_t;

    logic [31:0] exp_addr_q[$];
    pte_t        pte_q[$];
    res_t        exp_res_q[$];

    int total = 0;
    int bad = 0;
    int ack_delay = 0;
    pte_t rsp;
    res_t r;
    bit   gone;

    always #5 clk = ~clk;

    tlb_refill_walker dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req_i   (miss_req_i),
        .miss_vaddr_i (miss_vaddr_i),
        .ptbase_i     (ptbase_i),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .tlb_we_o     (tlb_we_o),
        .tlb_windex_o (tlb_windex_o),
        .tlb_vpn_o    (tlb_vpn_o),
        .tlb_ppn_o    (tlb_ppn_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fault_o      (fault_o)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string msg);
        total++;
        bad++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // memory responder: checks each request address, then acks after ack_delay
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        mem_err_i   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_o) begin
                gone = 1'b0;
                if (exp_addr_q.size() == 0)
                    fail_msg("unexpected_req",
                             $sformatf("addr %h", mem_addr_o));
                else
                    check("mem_addr", mem_addr_o, exp_addr_q.pop_front());
                for (int d = 0; d < ack_delay; d++) begin
                    @(negedge clk);
                    if (rst) begin
                        gone = 1'b1;
                        break;
                    end
                    check("req_held", 32'(mem_req_o), 32'd1);
                end
                if (!gone) begin
                    if (pte_q.size() == 0) begin
                        fail_msg("no_pte", "request with no response queued");
                        rsp.data = 32'h0;
                        rsp.err  = 1'b1;
                    end else begin
                        rsp = pte_q.pop_front();
                    end
                    mem_rdata_i = rsp.data;
                    mem_err_i   = rsp.err;
                    mem_ack_i   = 1'b1;
                    @(posedge clk);
                    #1;
                    mem_ack_i   = 1'b0;
                    mem_err_i   = 1'b0;
                    mem_rdata_i = '0;
                end
            end
        end
    end

    // result monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (tlb_we_o || fault_o || done_o)) begin
                if (exp_res_q.size() == 0) begin
                    fail_msg("unexpected_result",
                             $sformatf("we=%0b done=%0b fault=%0b",
                                       tlb_we_o, done_o, fault_o));
                end else begin
                    r = exp_res_q.pop_front();
                    if (r.is_fault) begin
                        check("fault_o", 32'(fault_o), 32'd1);
                        check("we_on_fault", 32'(tlb_we_o), 32'd0);
                        check("done_on_fault", 32'(done_o), 32'd0);
                    end else begin
                        check("tlb_we", 32'(tlb_we_o), 32'd1);
                        check("done", 32'(done_o), 32'd1);
                        check("fault_on_write", 32'(fault_o), 32'd0);
                        check("windex", 32'(tlb_windex_o), 32'(r.idx));
                        check("vpn", 32'(tlb_vpn_o), 32'(r.vpn));
                        check("ppn", 32'(tlb_ppn_o), 32'(r.ppn));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst        = 1'b1;
        miss_req_i = 1'b0;
        flush_i    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) fail_msg("walk_timeout", "busy_o stuck high");
    endtask

    task automatic issue(input logic [31:0] va);
        @(negedge clk);
        miss_req_i   = 1'b1;
        miss_vaddr_i = va;
        @(negedge clk);
        check("busy_set", 32'(busy_o), 32'd1);
        wait_idle();
        miss_req_i = 1'b0;
    endtask

    task automatic good_walk(input logic [31:0] va, input logic [31:0] addr,
                             input logic [19:0] ppn, input logic [3:0] idx,
                             input int dly);
        ack_delay = dly;
        exp_addr_q.push_back(addr);
        pte_q.push_back('{{ppn, 12'h001}, 1'b0});
        exp_res_q.push_back('{1'b0, idx, va[31:12], ppn});
        issue(va);
    endtask

    task automatic fault_walk(input logic [31:0] va, input logic [31:0] addr,
                              input logic [31:0] pte, input bit err);
        ack_delay = 2;
        exp_addr_q.push_back(addr);
        pte_q.push_back('{pte, err});
        exp_res_q.push_back('{1'b1, 4'h0, 20'h0, 20'h0});
        issue(va);
    endtask

    initial begin
        logic [19:0] vpn;
        logic [19:0] ppn;
        rst          = 1'b1;
        miss_req_i   = 1'b0;
        miss_vaddr_i = '0;
        flush_i      = 1'b0;
        ptbase_i     = 32'h0040_0000;
        do_reset();

        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_we", 32'(tlb_we_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_windex", 32'(tlb_windex_o), 32'd0);

`ifdef TLB_WALK_L2_EN
        ptbase_i  = 32'h0010_0000;
        ack_delay = 0;
        exp_addr_q.push_back(32'h0010_0120);
        exp_addr_q.push_back(32'h0020_0D14);
        pte_q.push_back('{32'h0020_0001, 1'b0});
        pte_q.push_back('{32'hABCD_E001, 1'b0});
        exp_res_q.push_back('{1'b0, 4'h0, 20'h12345, 20'hABCDE});
        issue(32'h1234_5678);

        fault_walk(32'h1234_5678, 32'h0010_0120, 32'h0020_0000, 1'b0);

        ack_delay = 3;
        exp_addr_q.push_back(32'h0010_0120);
        pte_q.push_back('{32'h0020_0001, 1'b0});
        @(negedge clk);
        miss_req_i   = 1'b1;
        miss_vaddr_i = 32'h1234_5678;
        @(negedge clk);
        flush_i    = 1'b1;
        miss_req_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        wait_idle();
        check("l1_flush_idle", 32'(busy_o), 32'd0);

        ack_delay = 1;
        exp_addr_q.push_back(32'h0010_0000);
        exp_addr_q.push_back(32'h0055_5004);
        pte_q.push_back('{32'h0055_5001, 1'b0});
        pte_q.push_back('{32'h7777_7001, 1'b0});
        exp_res_q.push_back('{1'b0, 4'h1, 20'h00001, 20'h77777});
        issue(32'h0000_1000);
`else
        // minimum-latency walk with explicit cycle checks
        ack_delay = 0;
        exp_addr_q.push_back(32'h0044_8D14);
        pte_q.push_back('{32'hABCD_E001, 1'b0});
        exp_res_q.push_back('{1'b0, 4'h0, 20'h12345, 20'hABCDE});
        @(negedge clk);
        miss_req_i   = 1'b1;
        miss_vaddr_i = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("lat_req_c1", 32'(mem_req_o), 32'd1);
        @(posedge clk);
        #1;
        check("lat_we_c2", 32'(tlb_we_o), 32'd1);
        @(negedge clk);
        wait_idle();
        miss_req_i = 1'b0;
        check("hold_we", 32'(tlb_we_o), 32'd0);
        check("hold_vpn", 32'(tlb_vpn_o), 32'h12345);
        check("hold_ppn", 32'(tlb_ppn_o), 32'hABCDE);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            vpn = 20'hA0000 + 20'(i);
            ppn = 20'h50000 + 20'(i * 3);
            good_walk({vpn, 12'h0}, {10'h001, vpn, 2'b00}, ppn,
                      4'(i % 16), i % 3);
            check("busy_between", 32'(busy_o), 32'd0);
        end

        fault_walk(32'h1234_5678, 32'h0044_8D14, 32'hABCD_E000, 1'b0);
        good_walk(32'h0000_1000, 32'h0040_0004, 20'h11111, 4'h1, 1);

        @(negedge clk);
        miss_req_i   = 1'b1;
        miss_vaddr_i = 32'h0000_5000;
        flush_i      = 1'b1;
        @(negedge clk);
        miss_req_i = 1'b0;
        flush_i    = 1'b0;
        check("flush_idle_nostart", 32'(busy_o), 32'd0);
        check("flush_idle_noreq", 32'(mem_req_o), 32'd0);

        ack_delay = 5;
        exp_addr_q.push_back(32'h0044_8D14);
        pte_q.push_back('{32'hABCD_E001, 1'b0});
        @(negedge clk);
        miss_req_i   = 1'b1;
        miss_vaddr_i = 32'h1234_5678;
        @(negedge clk);
        check("flush_busy", 32'(busy_o), 32'd1);
        flush_i    = 1'b1;
        miss_req_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        wait_idle();
        check("flush_fetch_idle", 32'(busy_o), 32'd0);
        good_walk(32'h0000_2000, 32'h0040_0008, 20'h22222, 4'h2, 0);

        fault_walk(32'h1234_5678, 32'h0044_8D14, 32'hABCD_E001, 1'b1);
        good_walk(32'h0000_4000, 32'h0040_0010, 20'h44444, 4'h3, 2);

        ack_delay = 10;
        exp_addr_q.push_back(32'h0040_000C);
        @(negedge clk);
        miss_req_i   = 1'b1;
        miss_vaddr_i = 32'h0000_3000;
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req_o), 32'd1);
        @(negedge clk);
        #2;
        rst        = 1'b1;
        miss_req_i = 1'b0;
        #1;
        check("rst_async_req", 32'(mem_req_o), 32'd0);
        check("rst_async_busy", 32'(busy_o), 32'd0);
        check("rst_async_addr", mem_addr_o, 32'd0);
        check("rst_async_vpn", 32'(tlb_vpn_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        good_walk(32'h0000_3000, 32'h0040_000C, 20'h33333, 4'h0, 1);
`endif

        repeat (5) @(negedge clk);
        check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check("pte_q_empty", 32'(pte_q.size()), 32'd0);
        check("res_q_empty", 32'(exp_res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
